// File: rtl/frame_scanout_reader_if.sv
// SDRAM read port shared between the frame scanout reader (master) and the
// memory arbiter (slave).
interface frame_scanout_reader_if;
  logic         sdram_wait;
  logic         sdram_ac;
  logic         sdram_rdvalid;
  logic [127:0] sdram_rddata;
  logic         sdram_rd;
  logic [21:0]  sdram_addr;

  // Handshake: the master raises sdram_rd only while sdram_wait was low and holds
  // sdram_rd with a stable sdram_addr until a one-cycle sdram_ac; every accepted
  // read returns exactly one sdram_rdvalid beat later, with at most one read outstanding.
  modport master (
    input  sdram_wait, sdram_ac, sdram_rdvalid, sdram_rddata,
    output sdram_rd, sdram_addr
  );
  modport slave (
    output sdram_wait, sdram_ac, sdram_rdvalid, sdram_rddata,
    input  sdram_rd, sdram_addr
  );
endinterface

// File: rtl/frame_scanout_reader.sv
// Fetches display lines from the front frame buffer into a two-line ping-pong
// buffer and serves one registered palette index per pixel to the colour mapper.
module frame_scanout_reader #(
  parameter int          H_WORDS   = 40,
  parameter int          V_LINES   = 480,
  parameter logic [21:0] OFFSET0   = 22'h100000,
  parameter logic [21:0] OFFSET1   = 22'h200000,
  parameter logic [7:0]  BLANK_PIX = 8'h00
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   new_frame,
  input  logic                   frame_flip,
  input  logic [9:0]             draw_x,
  input  logic [9:0]             draw_y,
  frame_scanout_reader_if.master sdram,
  output logic [7:0]             pixel,
  output logic                   busy,
  output logic                   underrun,
  output logic [2:0]             o_dbg_state
);
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ    = 3'd1,
    S_WAIT_D = 3'd2,
    S_NEXT   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam int         BUF_WORDS   = 2 * H_WORDS;
  localparam logic [9:0] L_X_END     = 10'd640;
  localparam logic [9:0] L_V_LINES   = 10'(V_LINES);
  localparam logic [5:0] L_LAST_WORD = 6'(H_WORDS - 1);

  state_t       r_state, w_next;
  logic         r_disp_sel;
  logic [1:0]   r_ready;
  logic [8:0]   r_fetch_y;
  logic [5:0]   r_word;
  logic         r_pend;
  logic [8:0]   r_pend_y;
  logic         r_abort;
  logic         r_x0_prev;
  logic [7:0]   r_pixel;
  logic         r_underrun;
  logic [127:0] r_buf [BUF_WORDS];

  logic         w_x0_rise, w_line_trig, w_any_trig, w_visible;
  logic [8:0]   w_trig_y;
  logic [21:0]  w_addr;
  logic [6:0]   w_rd_idx, w_wr_idx;
  logic [127:0] w_rd_word;
  logic         w_start, w_wr_en, w_done;

  // Edge-qualified so a column 0 that lasts several clocks fires only once.
  assign w_x0_rise   = (draw_x == 10'd0) && !r_x0_prev;
  assign w_line_trig = w_x0_rise && (draw_y < L_V_LINES - 10'd1);
  assign w_any_trig  = new_frame || w_line_trig;
  assign w_trig_y    = 9'(draw_y + 10'd1);
  assign w_visible   = (draw_x < L_X_END) && (draw_y < L_V_LINES);
  assign w_addr      = (r_disp_sel ? OFFSET1 : OFFSET0)
                     + 22'(r_fetch_y) * 22'(H_WORDS) + 22'(r_word);
  assign w_rd_idx    = (draw_y[0] ? 7'(H_WORDS) : 7'd0) + 7'(draw_x[9:4]);
  assign w_wr_idx    = (r_fetch_y[0] ? 7'(H_WORDS) : 7'd0) + 7'(r_word);
  assign w_rd_word   = r_buf[w_rd_idx];

  always_comb begin
    w_next           = r_state;
    w_start          = 1'b0;
    w_wr_en          = 1'b0;
    w_done           = 1'b0;
    busy             = 1'b0;
    sdram.sdram_rd   = 1'b0;
    sdram.sdram_addr = 22'd0;
    case (r_state)
      // A trigger landing this cycle is taken next cycle so it is never lost.
      S_IDLE: begin
        if (r_pend && !sdram.sdram_wait && !w_any_trig) begin
          w_next  = S_REQ;
          w_start = 1'b1;
        end
      end
      S_REQ: begin
        busy             = 1'b1;
        sdram.sdram_rd   = 1'b1;
        sdram.sdram_addr = w_addr;
        if (sdram.sdram_ac)  w_next = S_WAIT_D;
        else if (new_frame)  w_next = S_IDLE;
      end
      S_WAIT_D: begin
        busy = 1'b1;
        if (sdram.sdram_rdvalid) begin
          w_wr_en = !(r_abort || new_frame);
          w_next  = (r_abort || new_frame) ? S_IDLE : S_NEXT;
        end
      end
      S_NEXT: begin
        busy = 1'b1;
        if (new_frame)                   w_next = S_IDLE;
        else if (r_word == L_LAST_WORD)  w_next = S_DONE;
        else if (!sdram.sdram_wait)      w_next = S_REQ;
      end
      S_DONE: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_disp_sel <= 1'b0;
      r_ready    <= 2'b00;
      r_fetch_y  <= 9'd0;
      r_word     <= 6'd0;
      r_pend     <= 1'b0;
      r_pend_y   <= 9'd0;
      r_abort    <= 1'b0;
      r_x0_prev  <= 1'b1;
      r_pixel    <= 8'h00;
      r_underrun <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_x0_prev <= (draw_x == 10'd0);
      r_pixel   <= w_visible ? w_rd_word[{draw_x[3:0], 3'b000} +: 8] : BLANK_PIX;
      // An accepted read still owes its data beat; remember to discard it.
      r_abort   <= (w_next == S_WAIT_D) && (r_abort || new_frame);
      if (w_start) begin
        r_fetch_y <= r_pend_y;
        r_word    <= 6'd0;
        r_pend    <= 1'b0;
      end
      if (r_state == S_NEXT && w_next == S_REQ) r_word <= r_word + 6'd1;
      if (w_done) r_ready[r_fetch_y[0]] <= 1'b1;
      if (new_frame) begin
        r_disp_sel <= ~frame_flip;
        r_ready    <= 2'b00;
        r_pend     <= 1'b1;
        r_pend_y   <= 9'd0;
      end else if (w_line_trig) begin
        r_ready[w_trig_y[0]] <= 1'b0;
        r_pend               <= 1'b1;
        r_pend_y             <= w_trig_y;
      end
      if (w_x0_rise && (draw_y < L_V_LINES) && !r_ready[draw_y[0]]) r_underrun <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && w_wr_en) r_buf[w_wr_idx] <= sdram.sdram_rddata;
  end

  assign pixel       = r_pixel;
  assign underrun    = r_underrun;
  assign o_dbg_state = r_state;
endmodule

// File: tb/tb_frame_scanout_reader.sv
// Directed bench for frame_scanout_reader with a one-outstanding SDRAM responder
// and an expected-address queue.
module tb_frame_scanout_reader;
  logic       clk = 1'b0;
  logic       reset;
  logic       new_frame;
  logic       frame_flip;
  logic [9:0] draw_x;
  logic [9:0] draw_y;
  logic [7:0] pixel;
  logic       busy;
  logic       underrun;
  logic [2:0] dbg_state;

  logic [21:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int n_ack    = 0;
  int rd_cycles = 0;
  int rv_lat   = 2;

  frame_scanout_reader_if sdram();

  frame_scanout_reader dut (
    .clk        (clk),
    .reset      (reset),
    .new_frame  (new_frame),
    .frame_flip (frame_flip),
    .draw_x     (draw_x),
    .draw_y     (draw_y),
    .sdram      (sdram),
    .pixel      (pixel),
    .busy       (busy),
    .underrun   (underrun),
    .o_dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Byte k of the word at address a: {a[3:0], k} xor a[11:4].
  function automatic logic [127:0] word_data(input logic [21:0] a);
    logic [127:0] d;
    for (int k = 0; k < 16; k++) d[k*8 +: 8] = {a[3:0], 4'(k)} ^ a[11:4];
    return d;
  endfunction

  // SDRAM responder: acks any request at once, data rv_lat cycles after the ack.
  initial begin : sdram_model
    int          rv_cnt;
    logic [21:0] rv_addr;
    rv_cnt = 0;
    rv_addr = '0;
    sdram.sdram_ac = 1'b0;
    sdram.sdram_rdvalid = 1'b0;
    sdram.sdram_rddata = '0;
    forever begin
      @(posedge clk); #1;
      sdram.sdram_ac = 1'b0;
      sdram.sdram_rdvalid = 1'b0;
      if (rv_cnt > 0) begin
        rv_cnt--;
        if (rv_cnt == 0) begin
          sdram.sdram_rdvalid = 1'b1;
          sdram.sdram_rddata = word_data(rv_addr);
        end
      end
      if (sdram.sdram_rd) begin
        rd_cycles++;
        n_ack++;
        sdram.sdram_ac = 1'b1;
        rv_addr = sdram.sdram_addr;
        rv_cnt = rv_lat;
        check("req_expected", 1'(exp_q.size() != 0), 1'b1);
        if (exp_q.size() != 0) check("req_addr", sdram.sdram_addr, exp_q.pop_front());
      end
    end
  end

  // driver tasks (main thread acts 2 time units after each rising edge)
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk); #2;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step(3);
    reset = 1'b1;
  endtask

  task automatic pulse_new_frame(input logic flip);
    frame_flip = flip;
    new_frame = 1'b1;
    step(1);
    new_frame = 1'b0;
  endtask

  task automatic set_px(input int x, input int y);
    draw_x = 10'(x);
    draw_y = 10'(y);
    step(1);
  endtask

  task automatic check_px(input string tag, input int x, input int y, input logic [7:0] exp);
    set_px(x, y);
    check(tag, pixel, exp);
  endtask

  task automatic push_line(input logic [21:0] base, input int y, input int nwords);
    for (int w = 0; w < nwords; w++) exp_q.push_back(base + 22'(y * 40 + w));
  endtask

  task automatic wait_fetch(input string tag, input int budget);
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && dbg_state == 3'd0) && n < budget) begin
      step(1);
      n++;
    end
    check(tag, 1'(n < budget), 1'b1);
  endtask

  initial begin
    int n;
    reset = 1'b0;
    new_frame = 1'b0;
    frame_flip = 1'b0;
    draw_x = 10'd700;
    draw_y = 10'd500;
    sdram.sdram_wait = 1'b0;

    // reset state
    do_reset();
    step(1);
    check("rst_rd", sdram.sdram_rd, 1'b0);
    check("rst_addr", sdram.sdram_addr, 22'h0);
    check("rst_pixel", pixel, 8'h00);
    check("rst_underrun", underrun, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_state", dbg_state, 3'd0);

    // line 0 from buffer 1 (frame_flip=0)
    n_ack = 0;
    push_line(22'h200000, 0, 40);
    pulse_new_frame(1'b0);
    step(1);
    check("l0_busy", busy, 1'b1);
    check("l0_rd", sdram.sdram_rd, 1'b1);
    check("l0_addr0", sdram.sdram_addr, 22'h200000);
    wait_fetch("l0_done", 1000);
    check("l0_nreq", n_ack, 40);
    check("l0_busy_end", busy, 1'b0);

    // pixels of line 0; column 0 on row 0 also fetches line 1
    push_line(22'h200000, 1, 40);
    for (int x = 0; x < 16; x++) check_px("l0_pix", x, 0, 8'(x));
    check("l0_no_underrun", underrun, 1'b0);
    check_px("l0_pix300", 300, 0, 8'h2D);
    check_px("l0_pix639", 639, 0, 8'h7D);
    check_px("blank_x640", 640, 0, 8'h00);
    wait_fetch("l1_done", 1000);
    check_px("l1_pix1", 1, 1, 8'h83);
    check("l1_no_underrun", underrun, 1'b0);

    // frame_flip=1: reader uses buffer 0; line 6 fetched at 0x1000F0
    push_line(22'h100000, 0, 40);
    pulse_new_frame(1'b1);
    wait_fetch("f1_l0_done", 1000);
    set_px(700, 5);
    push_line(22'h100000, 6, 40);
    set_px(0, 5);
    check("l5_underrun", underrun, 1'b1);
    wait_fetch("l6_done", 1000);
    check_px("l6_pix5", 5, 6, 8'h0A);
    check_px("l6_pix1", 1, 6, 8'h0E);

    // new_frame while line 7 word 10 is awaiting data
    rv_lat = 8;
    set_px(700, 6);
    push_line(22'h100000, 7, 11);
    set_px(0, 6);
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      step(1);
      n++;
    end
    check("l7_w10_acked", 1'(n < 2000), 1'b1);
    step(1);
    check("l7_in_wait_d", dbg_state, 3'd2);
    push_line(22'h100000, 0, 40);
    pulse_new_frame(1'b1);
    check("abort_still_wait_d", dbg_state, 3'd2);
    check("abort_no_rd", sdram.sdram_rd, 1'b0);
    rv_lat = 2;
    wait_fetch("abort_l0_done", 2000);
    check_px("abort_blank", 700, 0, 8'h00);
    check_px("abort_l0_pix17", 17, 0, 8'h11);
    check_px("abort_no_write", 160, 7, 8'h23);

    // arbiter busy for 2000 cycles; display reaches line 0 unfetched
    do_reset();
    check("rst2_underrun", underrun, 1'b0);
    sdram.sdram_wait = 1'b1;
    set_px(700, 500);
    rd_cycles = 0;
    pulse_new_frame(1'b0);
    step(2000);
    check("wait_no_rd", rd_cycles, 0);
    check("wait_idle", dbg_state, 3'd0);
    set_px(0, 0);
    check("wait_underrun", underrun, 1'b1);
    step(5);
    check("wait_underrun_sticky", underrun, 1'b1);
    push_line(22'h200000, 1, 40);
    sdram.sdram_wait = 1'b0;
    wait_fetch("wait_l1_done", 1000);
    check("wait_underrun_end", underrun, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/frame_scanout_reader.md
Name: frame_scanout_reader

Overview:
- Reads the front frame buffer from SDRAM (128-bit words, 16 pixels × 8 bit, 40 words per 640-pixel line) into a two-line ping-pong buffer.
- Supplies one registered 8-bit palette index per pixel to the VGA colour mapper.
- It is the read side of the double-buffered frame store that the sprite/score blitters write.
- It always scans the buffer not selected by frame_flip.

Parameters:
- H_WORDS, 40, 128-bit words per line.
- V_LINES, 480, visible lines.
- OFFSET0, 22'h100000, base word address of buffer 0.
- OFFSET1, 22'h200000, base word address of buffer 1.
- BLANK_PIX, 8'h00, index output outside the visible area.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- new_frame  in  1  one-cycle pulse at the start of vertical blank.
- frame_flip  in  1  writers' target buffer; the reader uses the other one.
- draw_x  in  10  current pixel column from the VGA controller.
- draw_y  in  10  current pixel row from the VGA controller.
- sdram_wait  in  1  arbiter busy; do not raise a new request.
- sdram_ac  in  1  request accepted (one cycle).
- sdram_rdvalid  in  1  read data valid (one cycle).
- sdram_rddata  in  128  read data; pixel 0 is in [7:0].
- sdram_rd  out  1  read request.
- sdram_addr  out  22  word address.
- pixel  out  8  palette index, registered.
- busy  out  1  fetch in progress.
- underrun  out  1  sticky flag: a line was displayed before its fetch completed.

Behaviour:
- Reset (reset=0 at a clk edge): all outputs 0, state Idle, disp_sel=0, line-ready flags cleared.
  - pixel = 8'h00 even if BLANK_PIX differs.
- Line buffer: 2 × H_WORDS × 128 bit, indexed by line parity.
  - Write port is driven by the fetch FSM; the read port serves the pixel path.
- Pixel path, 1-cycle latency:
  - If draw_x < 640 and draw_y < V_LINES, pixel <= byte draw_x[3:0] of word draw_x[9:4] in buffer draw_y[0].
  - Otherwise pixel <= BLANK_PIX.
- On new_frame:
  - disp_sel <= ~frame_flip.
  - Clear both ready flags.
  - Queue a fetch of line 0.
- Fetch triggers:
  - Line 0 on new_frame.
  - Line y+1 when draw_x==0 and draw_y==y < V_LINES-1.
  - Line index is latched at trigger time as fetch_y.
- Address: (disp_sel ? OFFSET1 : OFFSET0) + fetch_y*H_WORDS + word, 22-bit wrap-free.
- FSM states: Idle, Req, Wait_d, Next, Done.
  - Idle: if a trigger is pending and ~sdram_wait → Req (word=0). A pending trigger waits in Idle while sdram_wait=1.
  - Req: sdram_rd=1, sdram_addr stable; hold until sdram_ac → Wait_d. sdram_rd drops the cycle after ac.
  - Wait_d: on sdram_rdvalid, write sdram_rddata to buf[fetch_y[0]][word] → Next.
  - Next: if word==H_WORDS-1 → Done; else word+1, then → Req if ~sdram_wait, otherwise stay in Next until sdram_wait=0.
  - Done: set ready[fetch_y[0]]=1 → Idle.
  - busy=1 in Req, Wait_d and Next.
- Only one outstanding read at a time.
- Clearing ready flags: ready[p] clears when its line's fetch trigger fires.
- underrun is set when draw_x==0, draw_y<V_LINES and ready[draw_y[0]]==0.
  - The stale buffer contents are still displayed.
  - Cleared only by reset.
- new_frame during a fetch:
  - A read already accepted (ac seen) must still consume its rdvalid.
  - Then the old fetch is abandoned and the line 0 fetch starts.
  - A pending Req that has not yet been accepted is dropped immediately.
- Trigger arriving while busy: latched (depth 1); the newer trigger overwrites an older pending one.
- reset low mid-fetch: immediate return to Idle; late rdvalid is ignored.

Test Plan:
- Reset held 3 cycles, then released with no stimulus → sdram_rd=0, pixel=8'h00, underrun=0, busy=0.
- frame_flip=0, new_frame pulse, arbiter acks immediately with rdvalid 2 cycles later → 40 requests at addresses 22'h200000..22'h200027, ready[0]=1, busy=0 after the last word.
- Word 0 of line 0 = 128'h0F0E…0100, then draw_y=0 and draw_x=0..15 → pixel=00..0F one cycle after each draw_x.
- draw_y=5, draw_x=0 with frame_flip=1 → line 6 fetched from OFFSET0+240 (22'h1000F0) into buffer 0.
- sdram_wait held 1 for 2000 cycles after new_frame, then display reaches line 0 → no requests issued while waiting, underrun=1 and stays 1.
- new_frame pulsed while in Wait_d of line 7 word 10 → waits for rdvalid, then first new request is to the base of line 0; draw_x=700 → pixel=BLANK_PIX.
